// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the single-clock fifo and its stream reader.
package fifo_stream_reader_pkg;

  localparam int unsigned FIFO_RD_LATENCY_DEFAULT = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// Pops the fifo read port ahead of demand and re-presents its words as a registered
// valid/ready stream; a credit-limited skid buffer hides the fifo RAM read latency.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = FIFO_RD_LATENCY_DEFAULT,
  localparam int unsigned BUF_DEPTH = RD_LATENCY + 2,
  localparam int unsigned PW        = clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
`ifdef FORMAL
  ,
  output logic [PW:0]           stored_o,
  output logic [PW:0]           inflight_o
`endif
);

  logic [DATA_WIDTH-1:0] skid_q [BUF_DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [PW:0]           stored_q, stored_d;
  logic [PW:0]           inflight;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                  valid_q, valid_d;
  logic                  rd_en;
  logic                  capture;
  logic                  consume;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (PW+1)'(pipe_q[i]);
    end
  end

  // Credits count words already held plus words still in the RAM pipe, so a
  // returning word always has a free slot regardless of m_ready_i.
  assign rd_en   = !rst && !fifo_empty_i && ((stored_q + inflight) < (PW+1)'(BUF_DEPTH));
  assign capture = pipe_q[RD_LATENCY-1];
  assign consume = valid_q && m_ready_i;

  always_comb begin
    pipe_d   = (pipe_q << 1) | RD_LATENCY'(rd_en);
    head_d   = consume ? ptr_inc(head_q) : head_q;
    tail_d   = capture ? ptr_inc(tail_q) : tail_q;
    stored_d = stored_q;
    unique case ({capture, consume})
      2'b10:   stored_d = stored_q + 1'b1;
      2'b01:   stored_d = stored_q - 1'b1;
      default: stored_d = stored_q;
    endcase
    valid_d = (stored_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      stored_q <= '0;
      pipe_q   <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        skid_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      stored_q <= stored_d;
      pipe_q   <= pipe_d;
      valid_q  <= valid_d;
      if (capture) begin
        skid_q[tail_q] <= fifo_rd_data_i;
      end
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = valid_q;
  assign m_data_o     = skid_q[head_q];

`ifdef FORMAL
  assign stored_o   = stored_q;
  assign inflight_o = inflight;

  always_comb begin
    if (!rst) begin
      assert ((stored_q + inflight) <= (PW+1)'(BUF_DEPTH));
      assert (!(rd_en && fifo_empty_i));
    end
  end
`endif

endmodule
